// File: rtl/see_arb_pkg.sv
// Types and defaults shared by the see_arb slice and its consumer (blockC).
// seeSt_t is the payload carried on every see-stream beat.
package see_arb_pkg;

  localparam int SEE_ARB_DEPTH_DEF = 2;
  localparam int SEE_ARB_CNT_W_DEF = 16;

  typedef struct packed {
    logic [3:0]  kind;
    logic [27:0] payload;
  } seeSt_t;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } srcId_t;

  function automatic srcId_t other_src(input srcId_t id);
    return (id == SRC0) ? SRC1 : SRC0;
  endfunction

endpackage

// File: rtl/rdy_vld_if.sv
// Ready/valid handshake carrying one seeSt_t per accepted beat.
// 'src' drives vld/data, 'dst' drives rdy.
interface rdy_vld_if;
  import see_arb_pkg::*;

  logic   vld;
  logic   rdy;
  seeSt_t data;

  modport src (output vld, output data, input rdy);
  modport dst (input vld, input data, output rdy);

endinterface

// File: rtl/see_arb_fifo.sv
// Small synchronous FIFO: registered count/pointers, head read straight from storage.
// Storage is not reset; the head is only meaningful while count_o != 0.
module see_arb_fifo
  import see_arb_pkg::*;
#(
  parameter int  DEPTH = SEE_ARB_DEPTH_DEF,
  parameter type T     = seeSt_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 head_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/see_arb.sv
// Round-robin merge of two rdy/vld producers into the registered 'see' stream.
// Producer rdy depends only on registered FIFO occupancy, never on see.rdy.
module see_arb
  import see_arb_pkg::*;
#(
  parameter int DEPTH = SEE_ARB_DEPTH_DEF,
  parameter int CNT_W = SEE_ARB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  rdy_vld_if.dst           src0,
  rdy_vld_if.dst           src1,
  rdy_vld_if.src           see,
  output logic [CNT_W-1:0] acc_cnt0,
  output logic [CNT_W-1:0] acc_cnt1
);

  localparam int FCNT_W = $clog2(DEPTH + 1);

  logic [FCNT_W-1:0] fifo_count;
  seeSt_t            fifo_head;
  seeSt_t            push_data;
  logic              space;
  logic              gnt_vld;
  srcId_t            gnt_id;
  logic              push;
  logic              pop;

  srcId_t            rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  acc_cnt0_q, acc_cnt0_d;
  logic [CNT_W-1:0]  acc_cnt1_q, acc_cnt1_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // rst_n gates space so neither producer sees rdy while reset is held.
  assign space = rst_n && (fifo_count < FCNT_W'(DEPTH));

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = SRC0;
    if (space) begin
      if (src0.vld && src1.vld) begin
        gnt_vld = 1'b1;
        gnt_id  = other_src(rr_last_q);
      end else if (src0.vld) begin
        gnt_vld = 1'b1;
        gnt_id  = SRC0;
      end else if (src1.vld) begin
        gnt_vld = 1'b1;
        gnt_id  = SRC1;
      end
    end
  end

  assign src0.rdy  = gnt_vld && (gnt_id == SRC0);
  assign src1.rdy  = gnt_vld && (gnt_id == SRC1);
  assign push      = gnt_vld;
  assign push_data = (gnt_id == SRC0) ? src0.data : src1.data;
  assign pop       = see.vld && see.rdy;

  always_comb begin
    rr_last_d  = push ? gnt_id : rr_last_q;
    acc_cnt0_d = (push && gnt_id == SRC0) ? sat_inc(acc_cnt0_q) : acc_cnt0_q;
    acc_cnt1_d = (push && gnt_id == SRC1) ? sat_inc(acc_cnt1_q) : acc_cnt1_q;
  end

  // rr_last resets to SRC1 so SRC0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q  <= SRC1;
      acc_cnt0_q <= '0;
      acc_cnt1_q <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      acc_cnt0_q <= acc_cnt0_d;
      acc_cnt1_q <= acc_cnt1_d;
    end
  end

  see_arb_fifo #(
    .DEPTH (DEPTH),
    .T     (seeSt_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign see.vld  = (fifo_count != '0);
  assign see.data = fifo_head;
  assign acc_cnt0 = acc_cnt0_q;
  assign acc_cnt1 = acc_cnt1_q;

endmodule

// File: tb/tb_see_arb.sv
// Bench for see_arb: directed scenarios plus random traffic against a queue-based
// model of the merged stream (occupancy, round-robin winner, saturating counts).
module tb_see_arb;
  import see_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] acc0, acc1;

  rdy_vld_if s0_if ();
  rdy_vld_if s1_if ();
  rdy_vld_if see_if ();

  see_arb #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src0     (s0_if),
    .src1     (s1_if),
    .see      (see_if),
    .acc_cnt0 (acc0),
    .acc_cnt1 (acc1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  seeSt_t mq[$];
  int     mlast;
  int     mc0, mc1;

  bit               e_r0, e_r1, e_vld;
  seeSt_t           e_data;
  logic [CNT_W-1:0] e_c0, e_c1;

  task automatic drive(input bit v0, input seeSt_t d0, input bit v1, input seeSt_t d1,
                       input bit sr);
    s0_if.vld   = v0;
    s0_if.data  = d0;
    s1_if.vld   = v1;
    s1_if.data  = d1;
    see_if.rdy  = sr;
  endtask

  task automatic mreset();
    mq.delete();
    mlast = 1;
    mc0   = 0;
    mc1   = 0;
  endtask

  function automatic logic [CNT_W-1:0] sat_model(input int n);
    return (n >= (1 << CNT_W) - 1) ? {CNT_W{1'b1}} : CNT_W'(n);
  endfunction

  task automatic predict();
    bit sp;
    sp   = (mq.size() < DEPTH);
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (sp) begin
      if (s0_if.vld && s1_if.vld) begin
        if (mlast == 1) e_r0 = 1'b1;
        else            e_r1 = 1'b1;
      end else if (s0_if.vld) e_r0 = 1'b1;
      else if (s1_if.vld)     e_r1 = 1'b1;
    end
    e_vld  = (mq.size() != 0);
    e_data = e_vld ? mq[0] : seeSt_t'(0);
    e_c0   = sat_model(mc0);
    e_c1   = sat_model(mc1);
  endtask

  task automatic advance();
    bit popf;
    popf = (mq.size() != 0) && see_if.rdy;
    if (popf) void'(mq.pop_front());
    if (e_r0) begin mq.push_back(s0_if.data); mlast = 0; mc0++; end
    if (e_r1) begin mq.push_back(s1_if.data); mlast = 1; mc1++; end
    @(posedge clk); #1;
  endtask

  function automatic string obs_s();
    return $sformatf("r0=%b r1=%b vld=%b data=%h c0=%0d c1=%0d",
                     s0_if.rdy, s1_if.rdy, see_if.vld, see_if.data, acc0, acc1);
  endfunction

  function automatic string exp_s();
    return $sformatf("r0=%b r1=%b vld=%b data=%h c0=%0d c1=%0d",
                     e_r0, e_r1, e_vld, e_data, e_c0, e_c1);
  endfunction

  function automatic bit model_mismatch();
    return ({s0_if.rdy, s1_if.rdy, see_if.vld, acc0, acc1} !== {e_r0, e_r1, e_vld, e_c0, e_c1})
        || (e_vld && (see_if.data !== e_data));
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    mreset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, seeSt_t'($urandom), 1'b0, seeSt_t'(0), 1'b0);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (see_if.vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", see_if.vld); end
    checks++;
    if (s0_if.rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy0 got %b exp 0", s0_if.rdy); end
    checks++;
    if ({acc0, acc1} !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", acc0, acc1); end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (s0_if.rdy !== 1'b1) begin errors++; $display("FAIL release_rdy0 got %b exp 1", s0_if.rdy); end
    #1;
    predict();
    advance();
    drive(1'b0, seeSt_t'(0), 1'b0, seeSt_t'(0), 1'b1);
    #4; predict(); checks++;
    if (model_mismatch()) begin errors++; $display("FAIL reset_first got %s exp %s", obs_s(), exp_s()); end
    advance();
  endtask

  task automatic test_contention();
    seeSt_t a[12], b[12], got[$];
    int ia = 0, ib = 0;
    for (int i = 0; i < 12; i++) begin a[i] = seeSt_t'($urandom); b[i] = seeSt_t'($urandom); end
    do_reset();
    for (int cyc = 0; cyc < 27; cyc++) begin
      bit hs0, hs1;
      drive(ia < 12, a[ia % 12], ib < 12, b[ib % 12], 1'b1);
      #4; predict(); checks++;
      if (model_mismatch()) begin errors++; $display("FAIL contention cyc=%0d got %s exp %s", cyc, obs_s(), exp_s()); end
      if (see_if.vld === 1'b1) got.push_back(see_if.data);
      hs0 = s0_if.vld && s0_if.rdy;
      hs1 = s1_if.vld && s1_if.rdy;
      advance();
      if (hs0) ia++;
      if (hs1) ib++;
    end
    checks++;
    if (got.size() != 24) begin errors++; $display("FAIL contention_len got %0d exp 24", got.size()); end
    for (int k = 0; k < 12 && 2 * k + 1 < got.size(); k++) begin
      checks++;
      if (got[2*k] !== a[k] || got[2*k+1] !== b[k]) begin
        errors++;
        $display("FAIL contention_order k=%0d got %h,%h exp %h,%h", k, got[2*k], got[2*k+1], a[k], b[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    seeSt_t c[3], got[$];
    int ic = 0;
    for (int i = 0; i < 3; i++) c[i] = seeSt_t'($urandom);
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      bit hs0;
      drive(ic < 3, c[ic % 3], 1'b0, seeSt_t'(0), cyc >= 4);
      #4; predict(); checks++;
      if (model_mismatch()) begin errors++; $display("FAIL backpressure cyc=%0d got %s exp %s", cyc, obs_s(), exp_s()); end
      if (cyc == 3) begin
        checks++;
        if (s0_if.rdy !== 1'b0 || see_if.data !== c[0]) begin
          errors++;
          $display("FAIL bp_full got rdy=%b head=%h exp rdy=0 head=%h", s0_if.rdy, see_if.data, c[0]);
        end
      end
      if (see_if.vld === 1'b1 && see_if.rdy) got.push_back(see_if.data);
      hs0 = s0_if.vld && s0_if.rdy;
      advance();
      if (hs0) ic++;
    end
    checks++;
    if (got.size() != 3 || got[0] !== c[0] || got[1] !== c[1] || got[2] !== c[2]) begin
      errors++;
      $display("FAIL bp_order got n=%0d exp %h %h %h", got.size(), c[0], c[1], c[2]);
    end
  endtask

  task automatic test_back_to_back();
    seeSt_t d[11], got[$];
    for (int i = 0; i < 11; i++) d[i] = seeSt_t'($urandom);
    do_reset();
    for (int cyc = 0; cyc < 13; cyc++) begin
      drive(cyc < 11, d[cyc % 11], 1'b0, seeSt_t'(0), cyc >= 1);
      #4; predict(); checks++;
      if (model_mismatch()) begin errors++; $display("FAIL back_to_back cyc=%0d got %s exp %s", cyc, obs_s(), exp_s()); end
      if (cyc >= 1 && cyc <= 10) begin
        checks++;
        if (s0_if.rdy !== 1'b1 || see_if.vld !== 1'b1) begin
          errors++;
          $display("FAIL b2b_steady cyc=%0d got rdy=%b vld=%b exp 1/1", cyc, s0_if.rdy, see_if.vld);
        end
      end
      if (see_if.vld === 1'b1 && see_if.rdy) got.push_back(see_if.data);
      advance();
    end
    checks++;
    if (got.size() != 11) begin errors++; $display("FAIL b2b_len got %0d exp 11", got.size()); end
    for (int k = 0; k < got.size() && k < 11; k++) begin
      checks++;
      if (got[k] !== d[k]) begin errors++; $display("FAIL b2b_order k=%0d got %h exp %h", k, got[k], d[k]); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int cyc = 0; cyc < 22; cyc++) begin
      drive(1'b0, seeSt_t'(0), cyc < 20, seeSt_t'($urandom), 1'b1);
      #4; predict(); checks++;
      if (model_mismatch()) begin errors++; $display("FAIL saturation cyc=%0d got %s exp %s", cyc, obs_s(), exp_s()); end
      advance();
    end
    checks++;
    if (acc1 !== 4'd15 || acc0 !== 4'd0) begin
      errors++;
      $display("FAIL sat_final got c0=%0d c1=%0d exp c0=0 c1=15", acc0, acc1);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive($urandom_range(0, 9) < 6, seeSt_t'($urandom), $urandom_range(0, 9) < 6,
            seeSt_t'($urandom), $urandom_range(0, 9) < 6);
      #4; predict(); checks++;
      if (model_mismatch()) begin errors++; $display("FAIL random cyc=%0d got %s exp %s", cyc, obs_s(), exp_s()); end
      advance();
    end
  endtask

  task automatic test_async_reset();
    seeSt_t n, first;
    bit sent = 1'b0, seen = 1'b0;
    n = seeSt_t'($urandom);
    do_reset();
    for (int cyc = 0; cyc < 2; cyc++) begin
      drive(1'b1, seeSt_t'($urandom), 1'b0, seeSt_t'(0), 1'b0);
      #4; predict(); checks++;
      if (model_mismatch()) begin errors++; $display("FAIL async_fill cyc=%0d got %s exp %s", cyc, obs_s(), exp_s()); end
      advance();
    end
    checks++;
    if (see_if.vld !== 1'b1) begin errors++; $display("FAIL async_prefill got vld=%b exp 1", see_if.vld); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (see_if.vld !== 1'b0 || s0_if.rdy !== 1'b0 || {acc0, acc1} !== '0) begin
      errors++;
      $display("FAIL async_assert got vld=%b rdy0=%b c0=%0d c1=%0d exp 0 0 0 0", see_if.vld, s0_if.rdy, acc0, acc1);
    end
    mreset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      bit hs0;
      drive(!sent, n, 1'b0, seeSt_t'(0), 1'b1);
      #4; predict(); checks++;
      if (model_mismatch()) begin errors++; $display("FAIL async_after cyc=%0d got %s exp %s", cyc, obs_s(), exp_s()); end
      if (!seen && see_if.vld === 1'b1) begin seen = 1'b1; first = see_if.data; end
      hs0 = s0_if.vld && s0_if.rdy;
      advance();
      if (hs0) sent = 1'b1;
    end
    checks++;
    if (!seen || first !== n) begin
      errors++;
      $display("FAIL async_first got seen=%b data=%h exp data=%h", seen, first, n);
    end
  endtask

  initial begin
    drive(1'b0, seeSt_t'(0), 1'b0, seeSt_t'(0), 1'b0);
    test_reset();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
